// File: rtl/stopwatch_lap.sv
// BCD stopwatch (HH:MM:SS.CC) with preset load and a first-word fall-through lap FIFO.
// Define STOPWATCH_LAP_DOWN_COUNT_EN for down-counting; the time output is time_bcd because "time" is reserved.
module stopwatch_lap #(
    parameter int unsigned DIV       = 500000,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned HOUR_MAX  = 99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] preset,
    input  logic        mode,
    input  logic        lap,
    input  logic        lap_ready,
    output logic [31:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic [31:0] lap_data,
    output logic        lap_valid,
    output logic        lap_overflow
);

    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned AW = $clog2(LAP_DEPTH);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(LAP_DEPTH);
    localparam logic [7:0] HOUR_MAX_BCD = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));

    typedef enum logic {
        STOPPED,
        RUNNING
    } run_state_e;

    // Returns {next digit, carry out}.
    function automatic logic [4:0] dig_inc(input logic [3:0] d, input logic [3:0] top,
                                           input logic cin);
        if (!cin) return {d, 1'b0};
        else if (d == top) return {4'd0, 1'b1};
        else return {d + 4'd1, 1'b0};
    endfunction

    function automatic logic [31:0] time_inc(input logic [31:0] t);
        logic [31:0] r;
        logic        c;
        r = t;
        {r[3:0],   c} = dig_inc(t[3:0],   4'd9, 1'b1);
        {r[7:4],   c} = dig_inc(t[7:4],   4'd9, c);
        {r[11:8],  c} = dig_inc(t[11:8],  4'd9, c);
        {r[15:12], c} = dig_inc(t[15:12], 4'd5, c);
        {r[19:16], c} = dig_inc(t[19:16], 4'd9, c);
        {r[23:20], c} = dig_inc(t[23:20], 4'd5, c);
        if (c) begin
            if (t[31:24] == HOUR_MAX_BCD) r[31:24] = '0;
            else if (t[27:24] == 4'd9) r[31:24] = {t[31:28] + 4'd1, 4'd0};
            else r[27:24] = t[27:24] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic preset_ok(input logic [31:0] p);
        return (p[3:0] <= 4'd9) && (p[7:4] <= 4'd9) && (p[11:8] <= 4'd9) &&
               (p[15:12] <= 4'd5) && (p[19:16] <= 4'd9) && (p[23:20] <= 4'd5) &&
               (p[27:24] <= 4'd9) && (p[31:24] <= HOUR_MAX_BCD);
    endfunction

    run_state_e    state_q, state_d;
    logic [31:0]   time_q, time_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;
    logic          tick, load_ok, ss_block, zero_hit;
    logic [31:0]   stepped;

    assign tick    = (state_q == RUNNING) && (pre_q == PRE_LAST);
    assign load_ok = load && (state_q == STOPPED) && preset_ok(preset);

`ifdef STOPWATCH_LAP_DOWN_COUNT_EN
    function automatic logic [4:0] dig_dec(input logic [3:0] d, input logic [3:0] top,
                                           input logic bin);
        if (!bin) return {d, 1'b0};
        else if (d == 4'd0) return {top, 1'b1};
        else return {d - 4'd1, 1'b0};
    endfunction

    // Saturates at zero so a down tick can never underflow into HOUR_MAX.
    function automatic logic [31:0] time_dec(input logic [31:0] t);
        logic [31:0] r;
        logic        b;
        r = t;
        if (t != '0) begin
            {r[3:0],   b} = dig_dec(t[3:0],   4'd9, 1'b1);
            {r[7:4],   b} = dig_dec(t[7:4],   4'd9, b);
            {r[11:8],  b} = dig_dec(t[11:8],  4'd9, b);
            {r[15:12], b} = dig_dec(t[15:12], 4'd5, b);
            {r[19:16], b} = dig_dec(t[19:16], 4'd9, b);
            {r[23:20], b} = dig_dec(t[23:20], 4'd5, b);
            if (b) begin
                if (t[27:24] == 4'd0) r[31:24] = {t[31:28] - 4'd1, 4'd9};
                else r[27:24] = t[27:24] - 4'd1;
            end
        end
        return r;
    endfunction

    assign stepped  = mode ? time_dec(time_q) : time_inc(time_q);
    assign zero_hit = tick && mode && (stepped == '0);
    assign ss_block = mode && (time_q == '0);
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign stepped     = time_inc(time_q);
    assign zero_hit    = 1'b0;
    assign ss_block    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = STOPPED;
            time_d  = '0;
            pre_d   = '0;
        end else if (load_ok) begin
            time_d = preset;
            pre_d  = '0;
        end else begin
            if (state_q == RUNNING) pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) time_d = stepped;
            // Tick is applied first; a simultaneous start_stop toggles afterwards.
            if (zero_hit) begin
                state_d = STOPPED;
                done_d  = 1'b1;
            end else if (start_stop && !ss_block) begin
                state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STOPPED;
            time_q  <= '0;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    assign time_bcd = time_q;
    assign running  = (state_q == RUNNING);
    assign done     = done_q;

    logic [31:0]   lap_mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, push, pop;

    assign lap_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = lap_valid && lap_ready && !clear;
    assign push      = lap && !clear && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (lap && full && !pop) lap_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) lap_mem[wr_ptr] <= time_q;
    end

    // Stale storage is never exposed: the output reads zero whenever the FIFO is empty.
    assign lap_data = lap_valid ? lap_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Randomized bench for stopwatch_lap: directed scenarios plus random pulses, checked every
// cycle against a centisecond-integer model with a queue-based lap FIFO.
module tb_stopwatch_lap;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HMAX  = 99;
    localparam int unsigned WRAP  = (HMAX + 1) * 360000;
`ifdef STOPWATCH_LAP_DOWN_COUNT_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start_stop, clear, load, mode, lap, lap_ready;
    logic [31:0] preset, time_bcd, lap_data;
    logic        running, done, lap_valid, lap_overflow;

    always #5 clk = ~clk;

    stopwatch_lap #(
        .DIV(DIV),
        .LAP_DEPTH(DEPTH),
        .HOUR_MAX(HMAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_stop(start_stop),
        .clear(clear),
        .load(load),
        .preset(preset),
        .mode(mode),
        .lap(lap),
        .lap_ready(lap_ready),
        .time_bcd(time_bcd),
        .running(running),
        .done(done),
        .lap_data(lap_data),
        .lap_valid(lap_valid),
        .lap_overflow(lap_overflow)
    );

    int unsigned m_t, m_pre;
    bit          m_run, m_done, m_ovf;
    logic [31:0] m_q[$];
    int unsigned n_pass, n_checks;

    function automatic logic [31:0] to_bcd(input int unsigned cs);
        int unsigned hh, mm, ss, cc;
        hh = cs / 360000;
        mm = (cs / 6000) % 60;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic int unsigned digit(input logic [31:0] p, input int i);
        logic [31:0] s;
        s = p >> (4 * i);
        return int'(s[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [31:0] p);
        for (int i = 0; i < 8; i++)
            if (digit(p, i) > 9) return 1'b0;
        return (digit(p, 3) * 10 + digit(p, 2) < 60) &&
               (digit(p, 5) * 10 + digit(p, 4) < 60) &&
               (digit(p, 7) * 10 + digit(p, 6) <= HMAX);
    endfunction

    function automatic int unsigned bcd_to_cs(input logic [31:0] p);
        return (digit(p, 7) * 10 + digit(p, 6)) * 360000 +
               (digit(p, 5) * 10 + digit(p, 4)) * 6000 +
               (digit(p, 3) * 10 + digit(p, 2)) * 100 +
               (digit(p, 1) * 10 + digit(p, 0));
    endfunction

    function automatic logic [31:0] rand_preset();
        case ($urandom_range(0, 3))
            0: return $urandom();
            1: return to_bcd($urandom_range(0, 10));
            2: return to_bcd($urandom_range(0, WRAP - 1));
            default: return to_bcd(HMAX * 360000 + 59 * 6000 + 59 * 100 + $urandom_range(90, 99));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Advances the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit          tick, pop, full, hit, dn;
        int unsigned t0;
        t0     = m_t;
        m_done = 1'b0;
        if (reset || clear) begin
            m_t   = 0;
            m_run = 1'b0;
            m_pre = 0;
            m_ovf = 1'b0;
            m_q.delete();
            return;
        end
        tick = m_run && (m_pre == DIV - 1);
        dn   = DOWN_EN && mode;
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() != 0) && lap_ready;
        if (pop) void'(m_q.pop_front());
        if (lap) begin
            if (!full || pop) m_q.push_back(to_bcd(t0));
            else m_ovf = 1'b1;
        end
        if (load && !m_run && bcd_ok(preset)) begin
            m_t   = bcd_to_cs(preset);
            m_pre = 0;
            return;
        end
        if (m_run) m_pre = tick ? 0 : m_pre + 1;
        hit = 1'b0;
        if (tick) begin
            if (dn) begin
                if (m_t <= 1) begin
                    m_t = 0;
                    hit = 1'b1;
                end else begin
                    m_t = m_t - 1;
                end
            end else begin
                m_t = (m_t + 1) % WRAP;
            end
        end
        if (hit) begin
            m_run  = 1'b0;
            m_done = 1'b1;
        end else if (start_stop && !(dn && t0 == 0)) begin
            m_run = !m_run;
        end
    endtask

    task automatic compare_all();
        check("time", time_bcd, to_bcd(m_t));
        check("running", 32'(running), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
        check("lap_valid", 32'(lap_valid), 32'(m_q.size() != 0));
        check("lap_data", lap_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
        check("lap_overflow", 32'(lap_overflow), 32'(m_ovf));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        reset      = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        lap        = 1'b0;
    endtask

    int unsigned n_done, n_pop, r;

    initial begin
        n_pass = 0;
        n_checks = 0;
        m_t = 0;
        m_pre = 0;
        m_run = 1'b0;
        m_done = 1'b0;
        m_ovf = 1'b0;
        start_stop = 1'b0;
        clear = 1'b0;
        load = 1'b0;
        lap = 1'b0;
        mode = 1'b0;
        lap_ready = 1'b0;
        preset = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step();
        reset = 1'b1;
        step();
        check("rst_time", time_bcd, 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_lap_valid", 32'(lap_valid), 32'h0);
        check("rst_lap_data", lap_data, 32'h0);

        start_stop = 1'b1;
        step();
        repeat (400) step();
        check("t100_time", time_bcd, 32'h00000100);
        check("t100_running", 32'(running), 32'h1);

        start_stop = 1'b1;
        step();
        load = 1'b1;
        preset = 32'h99595999;
        step();
        start_stop = 1'b1;
        step();
        repeat (4) step();
        check("wrap_time", time_bcd, 32'h0);
        check("wrap_running", 32'(running), 32'h1);

        start_stop = 1'b1;
        step();
        load = 1'b1;
        preset = 32'h12345678;
        step();
        check("load_ok", time_bcd, 32'h12345678);
        load = 1'b1;
        preset = 32'h00006000;
        step();
        check("load_rej_sec", time_bcd, 32'h12345678);
        load = 1'b1;
        preset = 32'h1234567A;
        step();
        check("load_rej_digit", time_bcd, 32'h12345678);

`ifdef STOPWATCH_LAP_DOWN_COUNT_EN
        mode = 1'b1;
        load = 1'b1;
        preset = 32'h00000002;
        step();
        start_stop = 1'b1;
        step();
        n_done = 0;
        repeat (8) begin
            step();
            if (done) n_done++;
        end
        check("down_time", time_bcd, 32'h0);
        check("down_running", 32'(running), 32'h0);
        check("down_done_cnt", n_done, 32'd1);
        start_stop = 1'b1;
        step();
        check("down_ss_ignored", 32'(running), 32'h0);
        mode = 1'b0;
`endif

        clear = 1'b1;
        step();
        start_stop = 1'b1;
        step();
        lap_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lap = 1'b1;
            step();
            repeat (7) step();
        end
        check("full_no_ovf", 32'(lap_overflow), 32'h0);
        lap = 1'b1;
        lap_ready = 1'b1;
        step();
        lap_ready = 1'b0;
        check("push_pop_full_ovf", 32'(lap_overflow), 32'h0);
        repeat (3) step();
        lap = 1'b1;
        step();
        check("ovf_set", 32'(lap_overflow), 32'h1);
        start_stop = 1'b1;
        step();
        lap_ready = 1'b1;
        n_pop = 0;
        repeat (6) begin
            if (lap_valid) n_pop++;
            step();
        end
        check("drain_count", n_pop, 32'd4);
        check("drain_empty", 32'(lap_valid), 32'h0);

        lap_ready = 1'b0;
        start_stop = 1'b1;
        step();
        repeat (4) begin
            lap = 1'b1;
            step();
            step();
        end
        clear = 1'b1;
        lap = 1'b1;
        step();
        check("clr_time", time_bcd, 32'h0);
        check("clr_running", 32'(running), 32'h0);
        check("clr_lap_valid", 32'(lap_valid), 32'h0);
        check("clr_ovf", 32'(lap_overflow), 32'h0);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 3) start_stop = 1'b1;
            else if (r < 4) clear = 1'b1;
            else if (r < 8) begin
                load = 1'b1;
                preset = rand_preset();
            end else if (r == 8) reset = 1'b1;
            if ($urandom_range(0, 9) == 0) lap = 1'b1;
            lap_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 Parameter DIV, default 500000: clk cycles per centisecond tick; minimum 2.
REQ-002 Parameter LAP_DEPTH, default 4: lap FIFO entries; power of two, minimum 2.
REQ-003 Parameter HOUR_MAX, default 99: highest hour value, either 23 or 99.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start_stop  in  1  single-cycle pulse, debounced upstream; toggles running.
REQ-007 clear  in  1  single-cycle pulse; zeroes time and flushes laps.
REQ-008 load  in  1  single-cycle pulse; copies preset into time.
REQ-009 preset  in  32  packed BCD HHMMSSCC preset value.
REQ-010 mode  in  1  count direction: 0 up, 1 down.
REQ-011 lap  in  1  single-cycle pulse; captures current time into the FIFO.
REQ-012 lap_ready  in  1  consumer accepts lap_data.
REQ-013 time  out  32  packed BCD HHMMSSCC: HH[31:24], MM[23:16], SS[15:8], CC[7:0].
REQ-014 running  out  1  counter active.
REQ-015 done  out  1  one-cycle pulse when a down-count reaches zero.
REQ-016 lap_data  out  32  oldest FIFO entry, first-word fall-through.
REQ-017 lap_valid  out  1  FIFO non-empty.
REQ-018 lap_overflow  out  1  sticky; a lap was dropped.

Function
REQ-019 Prescaler counts 0..DIV-1 while running; tick asserts in the cycle it equals DIV-1, then it wraps to 0; held when stopped, zeroed by reset/clear/load.
REQ-020 Up tick: CC 00..99 -> SS; SS tens 0..5 -> MM; MM tens 0..5 -> HH; HH 00..HOUR_MAX -> 00; all carries resolve in one cycle; full wrap keeps running.
REQ-021 Down tick: mirrored borrow chain; the tick reaching 00:00:00.00 clears running and pulses done the following cycle; no underflow.
REQ-022 time updates the cycle after the tick; start_stop takes effect the next cycle.
REQ-023 start_stop is ignored while mode=1 and time=0.
REQ-024 load is honoured only while stopped, and only if every digit is <=9, SS/MM tens are <=5 and HH is <=HOUR_MAX; otherwise time is unchanged.
REQ-025 Priority: reset > clear > load > start_stop; a tick coinciding with start_stop is applied, then running toggles.
REQ-026 A mode change while running takes effect at the next tick.
REQ-027 lap pushes the time value present in that cycle (pre-tick) whether running or stopped.
REQ-028 A push when full with no pop is dropped and sets lap_overflow; a push and pop in the same cycle while full both succeed.
REQ-029 A pop occurs on lap_valid && lap_ready; pushing into an empty FIFO raises lap_valid the next cycle.
REQ-030 clear: time, prescaler and running go to 0, the FIFO empties and lap_overflow clears in the next cycle; a lap in the same cycle is discarded.

Reset
REQ-031 While reset=1: time=0, prescaler=0, running=0, done=0, FIFO empty, lap_valid=0, lap_data=0, lap_overflow=0.
REQ-032 Reset mid-count or mid-drain discards all state; no partial FIFO contents survive.

Configuration
REQ-033 Macro STOPWATCH_LAP_DOWN_COUNT_EN defined: mode, down-count (REQ-021) and done are implemented.
REQ-034 Macro undefined: mode is ignored and counting is up only; done is tied 0; REQ-023 does not apply.

Verification (DIV=4)
REQ-035 reset, start_stop, 100 ticks -> time=0x00000100, running=1.
REQ-036 HOUR_MAX=99, load 0x99595999, start, 1 tick -> time=0x00000000, running=1; load 0x00006000 -> rejected, time unchanged.
REQ-037 Down (macro on): load 0x00000002, start, 2 ticks -> time=0, running=0, done high exactly 1 cycle; further start_stop -> running stays 0.
REQ-038 LAP_DEPTH=4, lap_ready=0, 5 laps at distinct times -> 4 stored, lap_overflow=1; lap_ready=1 -> first 4 values emerge in order, then lap_valid=0.
REQ-039 Full FIFO, lap and lap_ready together -> no overflow, count stays 4.
REQ-040 Running with full FIFO, clear -> next cycle time=0, running=0, lap_valid=0, lap_overflow=0.
